fir_decimator: RTL

Downstream consumer of the FIR filter stage's output. It takes the filtered sample stream (valid pulses with no backpressure) and keeps every M-th sample, with M set at run time. Kept samples are buffered in a small first-word-fall-through FIFO with a ready/valid output handshake, so the next stage can stall without stalling the filter. Overflow is reported through a sticky flag.

---
 rtl/fir_decimator_if.sv | 32 +++
 rtl/fir_decimator.sv | 106 ++++++++++
 2 files changed

// File: rtl/fir_decimator_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_decimator_if
//  Purpose  : Sample-in / ready-valid-out bundle for the FIR decimator.
//  Revision : 1.0  initial release
// ============================================================================
interface fir_decimator_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic signed [DATA_WIDTH-1:0]  data_in;
    logic                          valid_in;
    logic signed [DATA_WIDTH-1:0]  data_out;
    logic                          valid_out;
    logic                          ready_in;
    logic        [LEVEL_WIDTH-1:0] level;
    logic                          overflow;

    // Master drives samples and consumes the buffered stream.
    modport master (
        output data_in, valid_in, ready_in,
        input  data_out, valid_out, level, overflow
    );

    modport slave (
        input  data_in, valid_in, ready_in,
        output data_out, valid_out, level, overflow
    );
endinterface
`default_nettype wire

// File: rtl/fir_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : fir_decimator
//  Purpose  : Keeps every M-th filtered sample into a FWFT FIFO with sticky
//             overflow and ready/valid output.
//  Revision : 1.0  initial release
// ============================================================================
module fir_decimator #(
    parameter int DATA_WIDTH  = 16,
    parameter int RATIO_WIDTH = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic [RATIO_WIDTH-1:0] decim_ratio,
    input  wire logic                   clear,
    fir_decimator_if.slave              bus
);
    localparam int c_PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int c_LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic        [RATIO_WIDTH-1:0]   r_cnt;
    logic        [RATIO_WIDTH-1:0]   r_ratio_q;
    logic signed [DATA_WIDTH-1:0]    r_mem [FIFO_DEPTH];
    logic        [c_PTR_WIDTH-1:0]   r_wr_ptr;
    logic        [c_PTR_WIDTH-1:0]   r_rd_ptr;
    logic        [c_LEVEL_WIDTH-1:0] r_level;
    logic                            r_overflow;

    logic        [RATIO_WIDTH-1:0]   w_eff;
    logic                            w_accept;
    logic                            w_keep;
    logic                            w_full;
    logic                            w_pop;
    logic                            w_push;
    logic        [c_LEVEL_WIDTH-1:0] w_level_next;

    assign w_eff    = (decim_ratio < RATIO_WIDTH'(2)) ? RATIO_WIDTH'(1) : decim_ratio;
    assign w_accept = bus.valid_in && !clear;
    assign w_keep   = w_accept && (r_cnt == '0);
    assign w_full   = (r_level == c_LEVEL_WIDTH'(FIFO_DEPTH));
    assign w_pop    = (r_level != '0) && bus.ready_in && !clear;
    // A full FIFO still takes the write when the head leaves in the same cycle.
    assign w_push   = w_keep && (!w_full || w_pop);

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + c_LEVEL_WIDTH'(1);
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - c_LEVEL_WIDTH'(1);
        end
    end

    // Phase counter; the latched ratio only changes on a kept sample so a
    // running period always finishes with the ratio it started with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_ratio_q <= RATIO_WIDTH'(1);
        end else if (clear) begin
            r_cnt     <= '0;
        end else if (w_keep) begin
            r_ratio_q <= w_eff;
            r_cnt     <= (w_eff == RATIO_WIDTH'(1)) ? '0 : RATIO_WIDTH'(1);
        end else if (w_accept) begin
            r_cnt     <= (r_cnt == r_ratio_q - RATIO_WIDTH'(1)) ? '0
                                                                : r_cnt + RATIO_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.data_in;
                r_wr_ptr        <= r_wr_ptr + c_PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_WIDTH'(1);
            end
            if (w_keep && !w_push) begin
                r_overflow <= 1'b1;
            end
            r_level <= w_level_next;
        end
    end

    assign bus.data_out  = r_mem[r_rd_ptr];
    assign bus.valid_out = (r_level != '0);
    assign bus.level     = r_level;
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire
